// File: rtl/sram_like_slave_mem.sv
// sram_like_slave_mem: responder end of the sram-like bus.
// Requests are accepted into a small circular queue. Each entry counts down
// to zero and then completes in order; the word-addressed RAM is read or
// written only at completion, so read-after-write follows issue order.
module sram_like_slave_mem #(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 2,
    parameter int QDEPTH     = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int MEM_WORDS = 1 << ADDR_WIDTH;
    localparam logic [3:0] INIT_CNT = 4'(LATENCY - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(QDEPTH);

    // Everything needed to finish a transaction later, captured at accept.
    typedef struct packed {
        logic                  wr;
        logic [1:0]            size;
        logic [1:0]            lo;
        logic [ADDR_WIDTH-1:0] idx;
        logic [31:0]           wdata;
        logic                  bad;
    } payload_t;

    payload_t          q_data  [QDEPTH];
    logic [3:0]        q_cnt   [QDEPTH];
    logic [QDEPTH-1:0] q_valid;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              err_q;

    logic [31:0] mem [MEM_WORDS];

    payload_t head;
    logic     accept;
    logic     pop;
    logic     req_bad;
    logic     mem_we;
    logic [3:0] head_be;

    // Upper address bits fall outside the array and simply alias.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[31:ADDR_WIDTH+2];

    // Acceptance is purely combinational: a full queue refuses even if the head
    // leaves this same cycle, so the freed slot only shows up next cycle.
    assign addr_ok = req & resetn & (count < FULL_COUNT);
    assign accept  = req & addr_ok;

    assign head    = q_data[rd_ptr];
    assign data_ok = q_valid[rd_ptr] & (q_cnt[rd_ptr] == 4'd0);
    assign pop     = data_ok;
    assign err     = err_q;

    // Flag requests whose size is undefined or whose address is not aligned.
    always_comb begin
        req_bad = 1'b0;
        case (size)
            2'd0:    req_bad = 1'b0;
            2'd1:    req_bad = addr[0];
            2'd2:    req_bad = (addr[1:0] != 2'b00);
            default: req_bad = 1'b1;
        endcase
    end

    // Queue bookkeeping: valid bits, countdowns, pointers, occupancy and the sticky error.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q_valid <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_cnt[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < QDEPTH; i++) begin
                if (q_valid[i] && (q_cnt[i] != 4'd0)) begin
                    q_cnt[i] <= q_cnt[i] - 4'd1;
                end
            end
            if (pop) begin
                q_valid[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + PW'(1);
            end
            if (accept) begin
                q_valid[wr_ptr] <= 1'b1;
                q_cnt[wr_ptr]   <= INIT_CNT;
                wr_ptr          <= wr_ptr + PW'(1);
                if (req_bad) begin
                    err_q <= 1'b1;
                end
            end
            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Request payload is captured into the tail slot; it needs no reset because validity is tracked separately.
    always_ff @(posedge clk) begin
        if (accept) begin
            q_data[wr_ptr] <= '{
                wr:    wr,
                size:  size,
                lo:    addr[1:0],
                idx:   addr[ADDR_WIDTH+1:2],
                wdata: wdata,
                bad:   req_bad
            };
        end
    end

    // Byte lanes touched by the head write, derived from its size and low address bits.
    always_comb begin
        head_be = 4'b0000;
        case (head.size)
            2'd0:    head_be = 4'b0001 << head.lo;
            2'd1:    head_be = head.lo[1] ? 4'b1100 : 4'b0011;
            2'd2:    head_be = 4'b1111;
            default: head_be = 4'b0000;
        endcase
    end

    assign mem_we = data_ok & head.wr & ~head.bad;

    // RAM write port: only enabled lanes change, and only when the write completes.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we && head_be[b]) begin
                mem[head.idx][8*b +: 8] <= head.wdata[8*b +: 8];
            end
        end
    end

    // Read data is the whole word at the head index, and zero at every other time.
    always_comb begin
        rdata = 32'h0;
        if (data_ok && !head.wr) begin
            rdata = mem[head.idx];
        end
    end

endmodule
